// File: rtl/dp_bram.sv
// dp_bram: single-clock true dual-port block RAM with a power-up clear sweep.
// After reset the FSM walks RST -> CLEAR -> READY; CLEAR writes INIT_VAL to
// every word, one per cycle, and user access is only honoured in READY.
// Port A wins a same-address write conflict; addresses >= DEPTH are inert.
// Optional feature macro: DP_BRAM_COLLISION_DET_EN builds a registered
// same-address write-conflict flag; when undefined, collision is tied to 0.
module dp_bram #(
  parameter int                 DATA_W   = 8,
  parameter int                 ADDR_W   = 15,
  parameter int                 DEPTH    = 512,
  parameter int                 WR_FIRST = 0,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
  input  logic              clka,
  input  logic              rsta_n,
  input  logic              ena,
  input  logic              enb,
  input  logic              wea,
  input  logic              web,
  input  logic [ADDR_W-1:0] addra,
  input  logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] dina,
  input  logic [DATA_W-1:0] dinb,
  output logic [DATA_W-1:0] douta,
  output logic [DATA_W-1:0] doutb,
  output logic              busy,
  output logic              collision
);

  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_C  = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {RST, CLEAR, READY} state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    ptr_q;
  logic [DATA_W-1:0]   douta_q;
  logic [DATA_W-1:0]   doutb_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                ready;
  logic                a_in;
  logic                b_in;
  logic                wr_a;
  logic                wr_b;
  logic                clr_we;
  logic [IDX_W-1:0]    idx_a;
  logic [IDX_W-1:0]    idx_b;
  logic [DATA_W-1:0]   rd_a_d;
  logic [DATA_W-1:0]   rd_b_d;

  // Address decode, write qualification and next read data for both ports.
  always_comb begin
    ready  = (state_q == READY);
    clr_we = (state_q == CLEAR);
    a_in   = ({1'b0, addra} < DEPTH_C);
    b_in   = ({1'b0, addrb} < DEPTH_C);
    idx_a  = addra[IDX_W-1:0];
    idx_b  = addrb[IDX_W-1:0];
    wr_a   = ready && ena && wea && a_in;
    // Port B's write is dropped when port A writes the same word.
    wr_b   = ready && enb && web && b_in && !(wr_a && (addra == addrb));
    rd_a_d = '0;
    rd_b_d = '0;
    if (a_in) begin
      if ((WR_FIRST != 0) && wr_a) rd_a_d = dina;
      else                         rd_a_d = mem[idx_a];
    end
    if (b_in) begin
      if ((WR_FIRST != 0) && wr_b) rd_b_d = dinb;
      else                         rd_b_d = mem[idx_b];
    end
  end

  // Storage array: clear-sweep writes and user writes; nothing commits in a reset cycle.
  always_ff @(posedge clka) begin
    if (rsta_n) begin
      if (clr_we) mem[ptr_q] <= INIT_VAL;
      if (wr_b)   mem[idx_b] <= dinb;
      if (wr_a)   mem[idx_a] <= dina;
    end
  end

  // Control FSM with sweep pointer and registered read outputs.
  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      state_q <= RST;
      ptr_q   <= '0;
      douta_q <= '0;
      doutb_q <= '0;
    end else begin
      case (state_q)
        RST: begin
          state_q <= CLEAR;
          ptr_q   <= '0;
        end
        CLEAR: begin
          douta_q <= '0;
          doutb_q <= '0;
          if (ptr_q == LAST_C) begin
            state_q <= READY;
            ptr_q   <= '0;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        READY: begin
          if (ena) douta_q <= rd_a_d;
          if (enb) doutb_q <= rd_b_d;
        end
        default: state_q <= RST;
      endcase
    end
  end

  assign douta = douta_q;
  assign doutb = doutb_q;
  assign busy  = (state_q != READY);

`ifdef DP_BRAM_COLLISION_DET_EN
  logic collision_q;
  logic collision_d;

  // Flag an in-range same-address write from both ports in a READY cycle.
  always_comb begin
    collision_d = ready && ena && wea && enb && web && a_in && (addra == addrb);
  end

  // One-cycle registered collision pulse.
  always_ff @(posedge clka) begin
    if (!rsta_n) collision_q <= 1'b0;
    else         collision_q <= collision_d;
  end

  assign collision = collision_q;
`else
  assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_dp_bram.sv
// Testbench for dp_bram: two instances (read-first and write-first) share
// the same stimulus; a word-array reference model tracks memory contents.
module tb_dp_bram;

  localparam int DW  = 8;
  localparam int AW  = 15;
  localparam int DEP = 512;
`ifdef DP_BRAM_COLLISION_DET_EN
  localparam bit COL_EN = 1'b1;
`else
  localparam bit COL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena, enb, wea, web;
  logic [AW-1:0] addra, addrb;
  logic [DW-1:0] dina, dinb;
  logic [DW-1:0] douta0, doutb0, douta1, doutb1;
  logic          busy0, busy1, col0, col1;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mdl [DEP];
  logic [DW-1:0] ea0, ea1, eb0, eb1;
  logic          ecol;

  always #5 clk = ~clk;

  dp_bram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .WR_FIRST(0), .INIT_VAL(8'hA5)) dut0 (
    .clka(clk), .rsta_n(rst_n), .ena(ena), .enb(enb), .wea(wea), .web(web),
    .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
    .douta(douta0), .doutb(doutb0), .busy(busy0), .collision(col0));

  dp_bram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .WR_FIRST(1), .INIT_VAL(8'hA5)) dut1 (
    .clka(clk), .rsta_n(rst_n), .ena(ena), .enb(enb), .wea(wea), .web(web),
    .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
    .douta(douta1), .doutb(doutb1), .busy(busy1), .collision(col1));

  task automatic drive(input logic a_en, input logic a_we, input logic [AW-1:0] a_ad,
                       input logic [DW-1:0] a_d, input logic b_en, input logic b_we,
                       input logic [AW-1:0] b_ad, input logic [DW-1:0] b_d);
    ena = a_en; wea = a_we; addra = a_ad; dina = a_d;
    enb = b_en; web = b_we; addrb = b_ad; dinb = b_d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // One READY cycle: predict outputs from the word array, update it, clock.
  task automatic tick();
    bit a_ok, b_ok, wa, wb;
    a_ok = int'(addra) < DEP;
    b_ok = int'(addrb) < DEP;
    wa   = ena && wea && a_ok;
    wb   = enb && web && b_ok && !(wa && addra == addrb);
    if (ena) begin
      ea0 = a_ok ? mdl[addra[8:0]] : 8'h00;
      ea1 = wa ? dina : ea0;
    end
    if (enb) begin
      eb0 = b_ok ? mdl[addrb[8:0]] : 8'h00;
      eb1 = wb ? dinb : eb0;
    end
    ecol = COL_EN && ena && wea && enb && web && a_ok && (addra == addrb);
    if (wb) mdl[addrb[8:0]] = dinb;
    if (wa) mdl[addra[8:0]] = dina;
    @(posedge clk); #1;
  endtask

  task automatic model_cleared();
    for (int i = 0; i < DEP; i++) mdl[i] = 8'hA5;
    ea0 = '0; ea1 = '0; eb0 = '0; eb1 = '0; ecol = 1'b0;
  endtask

  // Counts cycles with busy high after the RST->CLEAR edge; port access is
  // attempted throughout and the outputs must stay 0.
  task automatic count_clear(output int n, output int bad_out);
    n = 0; bad_out = 0;
    while (busy0 && n < 2000) begin
      n++;
      if (douta0 !== 8'h00 || doutb0 !== 8'h00 || douta1 !== 8'h00) bad_out++;
      drive(1'b1, 1'b1, 15'd3, 8'h77, 1'b1, 1'b1, 15'd4, 8'h66);
      @(posedge clk); #1;
    end
    idle();
  endtask

  task automatic test_reset();
    int n, bad;
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 15'd2, 8'h55, 1'b1, 1'b0, 15'd2, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL rst_busy got=%b exp=1", busy0); end
    checks++; if (douta0 !== 8'h00 || doutb0 !== 8'h00) begin failures++; $display("FAIL rst_dout got=%h/%h exp=00/00", douta0, doutb0); end
    checks++; if (col0 !== 1'b0 || col1 !== 1'b0) begin failures++; $display("FAIL rst_collision got=%b/%b exp=0", col0, col1); end
    idle();
    rst_n = 1'b1;
    @(posedge clk); #1;
    count_clear(n, bad);
    checks++; if (n != DEP) begin failures++; $display("FAIL clear_len got=%0d exp=%0d", n, DEP); end
    checks++; if (bad != 0) begin failures++; $display("FAIL clear_dout_zero got=%0d nonzero cycles exp=0", bad); end
    model_cleared();
    drive(1'b1, 1'b0, 15'h1FF, 8'h00, 1'b1, 1'b0, 15'd3, 8'h00);
    tick();
    checks++; if (douta0 !== 8'hA5) begin failures++; $display("FAIL clear_word_1ff got=%h exp=a5", douta0); end
    checks++; if (doutb0 !== 8'hA5) begin failures++; $display("FAIL busy_write_ignored got=%h exp=a5", doutb0); end
    idle();
    tick();
  endtask

  task automatic test_latency_hold();
    drive(1'b1, 1'b1, 15'd5, 8'h3C, 1'b0, 1'b0, 15'd0, 8'h00);
    tick();
    drive(1'b0, 1'b0, 15'd0, 8'h00, 1'b1, 1'b0, 15'd5, 8'h00);
    tick();
    checks++; if (doutb0 !== 8'h3C || doutb1 !== 8'h3C) begin failures++; $display("FAIL lat_read got=%h/%h exp=3c", doutb0, doutb1); end
    drive(1'b0, 1'b0, 15'd0, 8'h00, 1'b0, 1'b0, 15'd6, 8'h00);
    tick();
    checks++; if (doutb0 !== 8'h3C) begin failures++; $display("FAIL hold_b got=%h exp=3c", doutb0); end
  endtask

  task automatic test_rdw();
    drive(1'b1, 1'b1, 15'd9, 8'h11, 1'b0, 1'b0, 15'd0, 8'h00);
    tick();
    drive(1'b1, 1'b1, 15'd9, 8'h22, 1'b1, 1'b0, 15'd9, 8'h00);
    tick();
    checks++; if (douta0 !== 8'h11) begin failures++; $display("FAIL rdw_read_first got=%h exp=11", douta0); end
    checks++; if (douta1 !== 8'h22) begin failures++; $display("FAIL rdw_write_first got=%h exp=22", douta1); end
    checks++; if (doutb0 !== 8'h11 || doutb1 !== 8'h11) begin failures++; $display("FAIL rdw_cross got=%h/%h exp=11", doutb0, doutb1); end
  endtask

  task automatic test_conflict();
    logic exp_c;
    exp_c = COL_EN;
    drive(1'b1, 1'b1, 15'd7, 8'hAA, 1'b1, 1'b1, 15'd7, 8'hBB);
    tick();
    checks++; if (col0 !== exp_c || col1 !== exp_c) begin failures++; $display("FAIL coll_pulse got=%b/%b exp=%b", col0, col1, exp_c); end
    idle();
    tick();
    checks++; if (col0 !== 1'b0) begin failures++; $display("FAIL coll_clear got=%b exp=0", col0); end
    drive(1'b1, 1'b0, 15'd7, 8'h00, 1'b0, 1'b0, 15'd0, 8'h00);
    tick();
    checks++; if (douta0 !== 8'hAA) begin failures++; $display("FAIL conflict_a_wins got=%h exp=aa", douta0); end
  endtask

  task automatic test_out_of_range();
    drive(1'b1, 1'b1, 15'd600, 8'h5A, 1'b0, 1'b0, 15'd0, 8'h00);
    tick();
    drive(1'b1, 1'b0, 15'd600, 8'h00, 1'b1, 1'b0, 15'd88, 8'h00);
    tick();
    checks++; if (douta0 !== 8'h00 || douta1 !== 8'h00) begin failures++; $display("FAIL oor_read got=%h/%h exp=00", douta0, douta1); end
    checks++; if (doutb0 !== 8'hA5) begin failures++; $display("FAIL oor_alias got=%h exp=a5", doutb0); end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int c = 0; c < 400; c++) begin
      logic [AW-1:0] aa, ab;
      aa = ($urandom_range(7, 0) == 0) ? 15'(500 + $urandom_range(29, 0)) : 15'($urandom_range(11, 0));
      ab = ($urandom_range(7, 0) == 0) ? 15'(500 + $urandom_range(29, 0)) : 15'($urandom_range(11, 0));
      drive(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), aa, 8'($urandom),
            1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), ab, 8'($urandom));
      tick();
      checks++;
      if (douta0 !== ea0 || douta1 !== ea1 || doutb0 !== eb0 || doutb1 !== eb1 ||
          col0 !== ecol || col1 !== ecol || busy0 !== 1'b0) begin
        failures++;
        if (bad < 10)
          $display("FAIL rand_cyc%0d got a=%h/%h b=%h/%h c=%b/%b busy=%b exp a=%h/%h b=%h/%h c=%b busy=0",
                   c, douta0, douta1, doutb0, doutb1, col0, col1, busy0, ea0, ea1, eb0, eb1, ecol);
        bad++;
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    int n, bad;
    drive(1'b1, 1'b1, 15'd20, 8'h99, 1'b1, 1'b0, 15'd20, 8'h00);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy0 !== 1'b1 || douta0 !== 8'h00 || doutb0 !== 8'h00) begin failures++; $display("FAIL rst_mid_access got busy=%b a=%h b=%h exp busy=1 a=00 b=00", busy0, douta0, doutb0); end
    idle();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 100 && busy0; i++) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL rst_mid_sweep_busy got=%b exp=1", busy0); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    count_clear(n, bad);
    checks++; if (n != DEP) begin failures++; $display("FAIL reclear_len got=%0d exp=%0d", n, DEP); end
    model_cleared();
    drive(1'b1, 1'b0, 15'd20, 8'h00, 1'b1, 1'b0, 15'd7, 8'h00);
    tick();
    checks++; if (douta0 !== 8'hA5 || doutb0 !== 8'hA5) begin failures++; $display("FAIL reclear_words got=%h/%h exp=a5", douta0, doutb0); end
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_cleared();
    test_reset();
    test_latency_hold();
    test_rdw();
    test_conflict();
    test_out_of_range();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dp_bram.md
DP_BRAM -- requirements
Module: dp_bram

Interface
REQ-001 Parameter DATA_W, 8, word width in bits.
REQ-002 Parameter ADDR_W, 15, address width in bits.
REQ-003 Parameter DEPTH, 512, number of words; SHALL satisfy 1 <= DEPTH <= 2**ADDR_W.
REQ-004 Parameter WR_FIRST, 0, read-during-write mode: 0 = read-first (old data), 1 = write-first (new data).
REQ-005 Parameter INIT_VAL, 0, DATA_W-bit value written to every word by the clear sweep.
REQ-006 clka  input  1  single clock for both ports; all state changes on its rising edge.
REQ-007 rsta_n  input  1  reset, synchronous, active-low.
REQ-008 ena / enb  input  1  port A / port B access enable.
REQ-009 wea / web  input  1  port A / port B write enable; qualified by ena / enb.
REQ-010 addra / addrb  input  ADDR_W  port A / port B word address.
REQ-011 dina / dinb  input  DATA_W  port A / port B write data.
REQ-012 douta / doutb  output  DATA_W  port A / port B registered read data.
REQ-013 busy  output  1  high while the clear sweep runs.
REQ-014 collision  output  1  registered flag: same-address write conflict in the previous cycle.

Function
REQ-015 FSM states: RST, CLEAR, READY. rsta_n low forces RST. First edge with rsta_n high moves RST to CLEAR.
REQ-016 CLEAR writes INIT_VAL to word 0, 1, ... DEPTH-1, one word per cycle, using an internal pointer; after word DEPTH-1 the FSM moves to READY. CLEAR therefore lasts exactly DEPTH cycles.
REQ-017 busy is high in RST and CLEAR, and low only in READY.
REQ-018 While busy, port enables are ignored: no user writes, and douta/doutb hold 0.
REQ-019 In READY, a port with en=1 registers the addressed word; the data appears on dout at the next edge (1-cycle latency).
REQ-020 In READY, a port with en=0 holds its previous dout value.
REQ-021 A write with en=1 and we=1 updates the word at that edge.
REQ-022 On a read of the written address in the same cycle: dout shows the old word if WR_FIRST=0, and din if WR_FIRST=1.
REQ-023 Cross-port read of an address being written by the other port in the same cycle returns the old word, regardless of WR_FIRST.
REQ-024 If both ports write the same address in the same cycle, port A's data is stored and port B's write is dropped.
REQ-025 Addresses >= DEPTH are out of range: writes are ignored and reads return 0.
REQ-026 Memory contents are not altered by rsta_n except through the subsequent CLEAR sweep.

Reset
REQ-027 While rsta_n is low (sampled at an edge): state = RST, sweep pointer = 0, douta = doutb = 0, busy = 1, collision = 0.
REQ-028 Reset asserted mid-CLEAR or mid-access aborts the current operation. The sweep restarts from word 0 after release. No partial user write is committed in the reset cycle.

Configuration
REQ-029 Macro DP_BRAM_COLLISION_DET_EN.
- Defined: collision goes to 1 for exactly one cycle after any READY cycle in which ena&wea&enb&web are all high with addra == addrb (in range); otherwise it is 0.
- Undefined: collision is tied to constant 0 and no compare logic is built.
- All other behaviour is identical in both builds.

Verification
REQ-030 Reset/clear: DEPTH=512, INIT_VAL=8'hA5; hold rsta_n low 3 cycles, then release -> busy high for exactly 512 cycles after release; afterwards a read of address 0x1FF returns 8'hA5 one cycle after the read.
REQ-031 Latency/hold: write 8'h3C to address 5 on port A; next cycle read address 5 on port B -> doutb = 8'h3C one edge later; then drop enb -> doutb stays 8'h3C.
REQ-032 Read-during-write: address 9 holds 8'h11; port A writes 8'h22 to address 9 while reading it -> douta = 8'h11 with WR_FIRST=0, and douta = 8'h22 with WR_FIRST=1; a same-cycle port B read of address 9 returns 8'h11 in both modes.
REQ-033 Conflict: both ports write address 7 (A = 8'hAA, B = 8'hBB) -> a later read returns 8'hAA; collision pulses 1 for one cycle with DP_BRAM_COLLISION_DET_EN defined, and stays 0 without it.
REQ-034 Out-of-range/reset mid-sweep: write to address 600 (DEPTH=512) -> no change to any word, and a read of address 600 returns 0; assert rsta_n low at clear cycle 100 -> after release, busy lasts a full 512 cycles again.
